// File: rtl/tt_sweep.sv
// tt_sweep: drives x,y,z through all eight combinations of a three-input
// function block. It captures one response bit per combination into an
// 8-bit table and reports whether the table equals the expected pattern,
// using a start/done handshake.
module tt_sweep #(
    parameter int unsigned SETTLE   = 2,      // extra wait cycles per combination, 0..15
    parameter logic [7:0]  EXPECTED = 8'h3A   // bit i = expected response for {x,y,z} = i
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned TBL_W  = 8;

    localparam logic [WCNT_W-1:0] SETTLE_W = WCNT_W'(SETTLE);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(7);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WCNT_W-1:0]  wcnt_q,  wcnt_d;
    logic [TBL_W-1:0]   tbl_q,   tbl_d;
    logic               match_q, match_d;
    logic [IDX_W-1:0]   xyz_q,   xyz_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // State and datapath registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            tbl_q   <= '0;
            match_q <= 1'b0;
            xyz_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            tbl_q   <= tbl_d;
            match_q <= match_d;
            xyz_q   <= xyz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; the registered outputs are derived from the next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        tbl_d   = tbl_q;
        match_d = match_q;
        xyz_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    tbl_d   = '0;
                    match_d = 1'b0;
                end
            end
            DRIVE: begin
                if (wcnt_q < SETTLE_W) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end else begin
                    // Last cycle of this combination: f_in has settled.
                    tbl_d[idx_q] = f_in;
                    wcnt_d       = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FINISH: begin
                // Table is complete here; compare the captured value.
                match_d = (tbl_q == EXPECTED);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs registered so they line up with the state they describe.
        if (state_d == DRIVE) begin
            xyz_d  = idx_d;
            busy_d = 1'b1;
        end
        done_d = (state_d == FINISH);
    end

    assign x         = xyz_q[2];
    assign y         = xyz_q[1];
    assign z         = xyz_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = tbl_q;
    assign match     = match_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep. It runs two instances against a cycle-count based
// reference model: one with SETTLE=2 and varied stimulus, and one with
// SETTLE=0 whose start input is held high.
module tb_tt_sweep;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: SETTLE=2
    logic start_a, f_a, x_a, y_a, z_a, busy_a, done_a, match_a;
    logic [7:0] table_a;
    int   mode_a;   // 0 = F2, 1 = tied 0, 2 = ~F2, 3 = random every cycle
    logic rbit_a;

    // Instance B: SETTLE=0, start held high
    logic start_b, f_b, x_b, y_b, z_b, busy_b, done_b, match_b;
    logic [7:0] table_b;

    // Reference function block: F2 = x'y'z + x'yz + xy'
    function automatic logic f2(input logic xx, input logic yy, input logic zz);
        return (~xx & ~yy & zz) | (~xx & yy & zz) | (xx & ~yy);
    endfunction

    assign f_a = (mode_a == 0) ? f2(x_a, y_a, z_a) :
                 (mode_a == 1) ? 1'b0 :
                 (mode_a == 2) ? ~f2(x_a, y_a, z_a) : rbit_a;
    assign f_b = f2(x_b, y_b, z_b);

    tt_sweep #(.SETTLE(2), .EXPECTED(8'h3A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .f_in(f_a),
        .x(x_a), .y(y_a), .z(z_a), .busy(busy_a), .done(done_a),
        .table_out(table_a), .match(match_a)
    );

    tt_sweep #(.SETTLE(0), .EXPECTED(8'h3A)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .f_in(f_b),
        .x(x_b), .y(y_b), .z(z_b), .busy(busy_b), .done(done_b),
        .table_out(table_b), .match(match_b)
    );

    // ---------------- behavioural model ----------------
    // t counts edges since the accepted start. The sweep spans 8*(S+1) edges.
    // The sample for index i lands at t = (i+1)*(S+1). done is shown at
    // t = 8*(S+1), and the next edge finishes the sweep.
    typedef struct {
        bit         active;
        int         t;
        logic [7:0] tbl;
        logic       match;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t m_reset();
        mdl_t m;
        m.active = 1'b0;
        m.t      = 0;
        m.tbl    = 8'h00;
        m.match  = 1'b0;
        return m;
    endfunction

    function automatic mdl_t m_step(input mdl_t m, input int s, input logic st, input logic f);
        mdl_t n;
        int   per;
        n   = m;
        per = s + 1;
        if (!m.active) begin
            if (st) begin
                n.active = 1'b1;
                n.t      = 0;
                n.tbl    = 8'h00;
                n.match  = 1'b0;
            end
        end else if (m.t == 8 * per) begin
            n.active = 1'b0;
            n.match  = (m.tbl == 8'h3A);
        end else begin
            n.t = m.t + 1;
            if ((m.t + 1) % per == 0) n.tbl[(m.t + 1) / per - 1] = f;
        end
        return n;
    endfunction

    // Expected {x,y,z,busy,done,table_out,match}
    function automatic logic [13:0] m_out(input mdl_t m, input int s);
        int         per;
        logic       bsy, dn;
        logic [2:0] xyz;
        per = s + 1;
        bsy = m.active && (m.t < 8 * per);
        dn  = m.active && (m.t == 8 * per);
        xyz = bsy ? 3'(m.t / per) : 3'd0;
        return {xyz, bsy, dn, m.tbl, m.match};
    endfunction

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int last_done_b = -1;
    bit pend_b = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One clock: let inputs settle, advance the models using the values seen
    // at the edge, then compare both DUTs with the models at the negedge.
    task automatic cycle();
        rbit_a = 1'($urandom);
        #1;
        if (!rst_n) begin
            ma = m_reset();
            mb = m_reset();
        end else begin
            ma = m_step(ma, 2, start_a, f_a);
            mb = m_step(mb, 0, start_b, f_b);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("model_a", {x_a, y_a, z_a, busy_a, done_a, table_a, match_a}, m_out(ma, 2));
        chk("model_b", {x_b, y_b, z_b, busy_b, done_b, table_b, match_b}, m_out(mb, 0));
        if (done_a) done_cnt_a++;
        if (done_b) begin
            if (last_done_b >= 0) chk("b_done_period", cyc - last_done_b, 10);
            last_done_b = cyc;
            pend_b      = 1'b1;
        end else if (pend_b) begin
            chk("b_table", table_b, 8'h3A);
            chk("b_match", match_b, 1'b1);
            pend_b = 1'b0;
        end
    endtask

    // One sweep on instance A; returns the result and the edges from start to done.
    task automatic run_sweep(input int md, input bit ign,
                             output logic [7:0] tbl, output logic m, output int lat);
        bit pulsed;
        mode_a  = md;
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        lat     = 0;
        pulsed  = 1'b0;
        while (!done_a && lat < 60) begin
            if (ign && !pulsed && {x_a, y_a, z_a} == 3'd3) begin
                start_a = 1'b1;
                pulsed  = 1'b1;
            end
            cycle();
            start_a = 1'b0;
            lat++;
        end
        chk("done_latency", lat, 24);
        if (ign) start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        tbl = table_a;
        m   = match_a;
    endtask

    logic [7:0] tbl;
    logic       m;
    int         lat;
    int         dc0;

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b1;
        mode_a  = 0;
        rbit_a  = 1'b0;
        ma      = m_reset();
        mb      = m_reset();
        repeat (2) cycle();
        chk("reset_outs_a", {x_a, y_a, z_a, busy_a, done_a, table_a, match_a}, 14'h0);
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("idle_busy_a", busy_a, 1'b0);

        // Nominal sweep
        run_sweep(0, 1'b0, tbl, m, lat);
        chk("nominal_table", tbl, 8'h3A);
        chk("nominal_match", m, 1'b1);

        // Fault detection
        run_sweep(1, 1'b0, tbl, m, lat);
        chk("zero_table", tbl, 8'h00);
        chk("zero_match", m, 1'b0);
        run_sweep(2, 1'b0, tbl, m, lat);
        chk("inv_table", tbl, 8'hC5);
        chk("inv_match", m, 1'b0);

        // Ignored starts mid-sweep and during done
        dc0 = done_cnt_a;
        run_sweep(0, 1'b1, tbl, m, lat);
        repeat (12) cycle();
        chk("ign_one_done", done_cnt_a - dc0, 1);
        chk("ign_no_resweep", busy_a, 1'b0);
        chk("ign_table", tbl, 8'h3A);

        // Reset mid-sweep at idx 5
        mode_a  = 0;
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        for (int i = 0; i < 40 && {x_a, y_a, z_a} != 3'd5; i++) cycle();
        chk("reached_idx5", {x_a, y_a, z_a}, 3'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_table", table_a, 8'h00);
        chk("abort_xyz", {x_a, y_a, z_a}, 3'd0);
        ma = m_reset();
        mb = m_reset();
        last_done_b = -1;
        pend_b      = 1'b0;
        dc0         = done_cnt_a;
        cycle();
        rst_n = 1'b1;
        repeat (30) cycle();
        chk("abort_no_done", done_cnt_a - dc0, 0);
        run_sweep(0, 1'b0, tbl, m, lat);
        chk("post_abort_table", tbl, 8'h3A);
        chk("post_abort_match", m, 1'b1);

        // Randomized sweeps, gaps and ignored starts; the model checks every cycle
        for (int r = 0; r < 8; r++) begin
            int md;
            repeat ($urandom_range(0, 3)) cycle();
            md = int'($urandom_range(0, 3));
            run_sweep(md, 1'($urandom), tbl, m, lat);
            if (md == 0) chk("rand_f2_table", tbl, 8'h3A);
            if (md == 2) chk("rand_inv_table", tbl, 8'hC5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
